// File: rtl/seg_scroll_ctrl.sv
// Scroll and multiplex sequencer for the 4-digit seven-segment banner.
// Steps a 4-digit window through MSG_LEN glyph codes with run/step/dir and a blank gap after wrap.
module seg_scroll_ctrl #(
   parameter int unsigned TICK_DIV    = 12_000_000,
   parameter int unsigned MUX_DIV     = 12_000,
   parameter int unsigned MSG_LEN     = 11,
   parameter int unsigned BLANK_TICKS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       step,
   input  logic       dir,
   output logic [3:0] code,
   output logic [3:0] an,
   output logic       wrap
);

   localparam int unsigned TW = $clog2(TICK_DIV);
   localparam int unsigned MW = $clog2(MUX_DIV);
   localparam int unsigned BW = $clog2(BLANK_TICKS + 1);

   typedef enum logic [1:0] {STOP, RUN, BLANK} state_t;

   state_t        state;
   logic [3:0]    offset;
   logic [1:0]    sel;
   logic [TW-1:0] tcnt;
   logic [MW-1:0] mcnt;
   logic [BW-1:0] bcnt;

   logic [4:0]    idx_c;
   logic          tick_c;
   logic          fwd_wrap_c;
   logic          rev_wrap_c;
   logic [3:0]    next_off_c;
   logic          next_wrap_c;

   // Window digit index with a single modulo correction, and the one-position offset step.
   always_comb begin
      idx_c = 5'(offset) + 5'(sel);
      if (idx_c >= 5'(MSG_LEN)) begin
         idx_c = idx_c - 5'(MSG_LEN);
      end
      tick_c     = (tcnt == TW'(TICK_DIV - 1));
      fwd_wrap_c = (offset == 4'(MSG_LEN - 1));
      rev_wrap_c = (offset == 4'd0);
      if (dir) begin
         next_off_c  = rev_wrap_c ? 4'(MSG_LEN - 1) : offset - 4'd1;
         next_wrap_c = rev_wrap_c;
      end else begin
         next_off_c  = fwd_wrap_c ? 4'd0 : offset + 4'd1;
         next_wrap_c = fwd_wrap_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= STOP;
         offset <= 4'd0;
         sel    <= 2'd0;
         tcnt   <= '0;
         mcnt   <= '0;
         bcnt   <= '0;
         code   <= 4'd0;
         an     <= 4'b1110;
         wrap   <= 1'b0;
      end else begin
         wrap <= 1'b0;
         code <= 4'(idx_c);
         an   <= (state == BLANK) ? 4'b1111 : ~(4'b0001 << sel);

         if (mcnt == MW'(MUX_DIV - 1)) begin
            mcnt <= '0;
            sel  <= sel + 2'd1;
         end else begin
            mcnt <= mcnt + MW'(1);
         end

         case (state)
            STOP: begin
               tcnt <= '0;
               if (run) begin
                  state <= RUN;
               end else if (step) begin
                  offset <= next_off_c;
                  wrap   <= next_wrap_c;
               end
            end
            RUN: begin
               if (!run) begin
                  state <= STOP;
                  tcnt  <= '0;
               end else if (tick_c) begin
                  tcnt   <= '0;
                  offset <= next_off_c;
                  wrap   <= next_wrap_c;
                  // Only a forward wrap opens the blank gap; reverse scrolling is seamless.
                  if (!dir && fwd_wrap_c) begin
                     state <= BLANK;
                     bcnt  <= '0;
                  end
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            BLANK: begin
               if (!run) begin
                  state <= STOP;
                  tcnt  <= '0;
                  bcnt  <= '0;
               end else if (tick_c) begin
                  tcnt <= '0;
                  if (bcnt == BW'(BLANK_TICKS - 1)) begin
                     state <= RUN;
                     bcnt  <= '0;
                  end else begin
                     bcnt <= bcnt + BW'(1);
                  end
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: state <= STOP;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Scoreboard bench for seg_scroll_ctrl: a time-based reference model pushes expected outputs
// each edge, and a negedge monitor pops and compares them against the DUT.
module tb_seg_scroll_ctrl;

   localparam int TICK_DIV    = 4;
   localparam int MUX_DIV     = 2;
   localparam int MSG_LEN     = 11;
   localparam int BLANK_TICKS = 2;

   localparam int M_STOP  = 0;
   localparam int M_RUN   = 1;
   localparam int M_BLANK = 2;

   typedef struct packed {
      logic [3:0] code;
      logic [3:0] an;
      logic       wrap;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       step = 1'b0;
   logic       dir = 1'b0;
   logic [3:0] code;
   logic [3:0] an;
   logic       wrap;

   int checks = 0;
   int errors = 0;

   exp_t sb[$];

   // Reference model state
   int m_n     = 0;   // clock edges since reset release
   int m_off   = 0;
   int m_mode  = M_STOP;
   int m_k     = 0;   // edges since entering RUN from STOP
   int m_until = 0;   // tick number on which the blank gap ends

   seg_scroll_ctrl #(
      .TICK_DIV   (TICK_DIV),
      .MUX_DIV    (MUX_DIV),
      .MSG_LEN    (MSG_LEN),
      .BLANK_TICKS(BLANK_TICKS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .run (run),
      .step(step),
      .dir (dir),
      .code(code),
      .an  (an),
      .wrap(wrap)
   );

   always #5 clk = ~clk;

   function automatic exp_t reset_exp();
      exp_t e;
      e.code = 4'd0;
      e.an   = 4'b1110;
      e.wrap = 1'b0;
      return e;
   endfunction

   // Reference model: digit slot from elapsed time, offset moved with modular arithmetic.
   always @(posedge clk) begin
      exp_t e;
      int   slot;
      int   t;
      bit   w;
      if (rst) begin
         m_n    = 0;
         m_off  = 0;
         m_mode = M_STOP;
         m_k    = 0;
         sb.push_back(reset_exp());
      end else begin
         slot   = (m_n / MUX_DIV) % 4;
         e.code = 4'((m_off + slot) % MSG_LEN);
         e.an   = (m_mode == M_BLANK) ? 4'b1111 : ~(4'(1) << slot);
         w      = 1'b0;
         if (m_mode == M_STOP) begin
            if (run) begin
               m_mode = M_RUN;
               m_k    = 0;
            end else if (step) begin
               m_off = dir ? (m_off + MSG_LEN - 1) % MSG_LEN : (m_off + 1) % MSG_LEN;
               w     = dir ? (m_off == MSG_LEN - 1) : (m_off == 0);
            end
         end else if (!run) begin
            m_mode = M_STOP;
         end else begin
            m_k = m_k + 1;
            if (m_k % TICK_DIV == 0) begin
               t = m_k / TICK_DIV;
               if (m_mode == M_RUN) begin
                  m_off = dir ? (m_off + MSG_LEN - 1) % MSG_LEN : (m_off + 1) % MSG_LEN;
                  w     = dir ? (m_off == MSG_LEN - 1) : (m_off == 0);
                  if (!dir && m_off == 0) begin
                     m_mode  = M_BLANK;
                     m_until = t + BLANK_TICKS;
                  end
               end else if (t == m_until) begin
                  m_mode = M_RUN;
               end
            end
         end
         e.wrap = w;
         m_n    = m_n + 1;
         sb.push_back(e);
      end
   end

   // Monitor: one expected entry per edge, compared half a cycle later.
   always @(negedge clk) begin
      exp_t e;
      checks = checks + 1;
      if (sb.size() == 0) begin
         errors = errors + 1;
         $display("FAIL sb_empty t=%0t no expected entry for code=%0d an=%b wrap=%b", $time, code, an, wrap);
      end else begin
         e = sb.pop_front();
         if (rst) e = reset_exp();
         if (code !== e.code || an !== e.an || wrap !== e.wrap) begin
            errors = errors + 1;
            $display("FAIL outputs t=%0t got code=%0d an=%b wrap=%b expected code=%0d an=%b wrap=%b",
                     $time, code, an, wrap, e.code, e.an, e.wrap);
         end
      end
   end

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_step(input logic d);
      dir  = d;
      step = 1'b1;
      cyc();
      step = 1'b0;
      cyc();
   endtask

   initial begin
      // Reset, then stopped refresh rotation
      cyc(3);
      rst = 1'b0;
      cyc(16);

      // Single steps forward to offset 3, then around to 0, then reverse wrap to 10
      for (int i = 0; i < 3; i++) pulse_step(1'b0);
      cyc(8);
      for (int i = 0; i < 8; i++) pulse_step(1'b0);
      pulse_step(1'b1);
      cyc(8);

      // From offset 9 run forward through the wrap and blank gap
      pulse_step(1'b1);
      dir = 1'b0;
      run = 1'b1;
      cyc(40);

      // Drop run in the middle of a blank gap, then step while stopped
      for (int i = 0; i < 200 && m_mode != M_BLANK; i++) cyc();
      cyc(2);
      run = 1'b0;
      cyc(8);
      pulse_step(1'b0);
      pulse_step(1'b0);

      // run and step on the same cycle: no step occurs
      run  = 1'b1;
      step = 1'b1;
      cyc();
      step = 1'b0;
      cyc(10);

      // Reset mid-run at offset 7, then stay stopped
      for (int i = 0; i < 200 && !(m_mode == M_RUN && m_off == 7); i++) cyc();
      cyc(2);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      run = 1'b0;
      cyc(10);

      // Randomized run/step/dir/reset traffic
      for (int i = 0; i < 3000; i++) begin
         rst  = 1'b0;
         step = ($urandom % 6) == 0;
         if (($urandom % 40) == 0) run = ~run;
         if (($urandom % 8) == 0) dir = 1'($urandom);
         if (($urandom % 500) == 0) rst = 1'b1;
         cyc();
      end
      rst  = 1'b0;
      step = 1'b0;
      cyc(4);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
